// File: rtl/core_pkg.sv
// Shared core definitions for the load/store unit.
// LSU FSM state codes, funct3 load/store encodings, the store payload struct
// and the misalignment predicate.
package core_pkg;

  localparam int unsigned XLEN = 32;
  localparam int unsigned BE_W = XLEN / 8;

  // LSU FSM state encoding
  typedef logic [1:0] lsu_state_t;
  localparam lsu_state_t LSU_IDLE    = 2'd0;
  localparam lsu_state_t LSU_RD_WAIT = 2'd1;
  localparam lsu_state_t LSU_DRAIN   = 2'd2;

  // RISC-V funct3 encodings for loads and stores
  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;
  localparam logic [2:0] F3_SB  = 3'b000;
  localparam logic [2:0] F3_SH  = 3'b001;
  localparam logic [2:0] F3_SW  = 3'b010;

  // Lane-formatted store payload presented on the data bus
  typedef struct packed {
    logic [BE_W-1:0] byteenable;
    logic [XLEN-1:0] writedata;
  } st_fmt_t;

  // Halfword needs addr[0]=0, word needs addr[1:0]=0; funct3[1:0] gives the size
  function automatic logic is_misaligned(input logic [2:0] f3, input logic [1:0] off);
    case (f3[1:0])
      2'b01:   return off[0];
      2'b10:   return (off != 2'b00);
      default: return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/lsu_if.sv
// Avalon-MM style data bus between the LSU (master) and memory (slave).
interface lsu_if;
  logic                       dbus_read;
  logic                       dbus_write;
  logic [core_pkg::XLEN-1:0]  dbus_address;
  logic [core_pkg::BE_W-1:0]  dbus_byteenable;
  logic [core_pkg::XLEN-1:0]  dbus_writedata;
  logic                       dbus_waitrequest;
  logic                       dbus_readdatavalid;
  logic [core_pkg::XLEN-1:0]  dbus_readdata;

  modport master (
    output dbus_read, dbus_write, dbus_address, dbus_byteenable, dbus_writedata,
    input  dbus_waitrequest, dbus_readdatavalid, dbus_readdata
  );

  modport slave (
    input  dbus_read, dbus_write, dbus_address, dbus_byteenable, dbus_writedata,
    output dbus_waitrequest, dbus_readdatavalid, dbus_readdata
  );
endinterface

// File: rtl/lsu_align.sv
// Combinational lane steering: store byteenable/data replication and
// load byte/halfword extraction with sign or zero extension.
module lsu_align
  import core_pkg::*;
(
  input  logic [2:0]      st_op,
  input  logic [1:0]      st_off,
  input  logic [XLEN-1:0] st_wdata,
  output st_fmt_t         st_fmt_c,
  input  logic [2:0]      ld_op,
  input  logic [1:0]      ld_off,
  input  logic [XLEN-1:0] ld_rdata,
  output logic [XLEN-1:0] ld_data_c
);

  logic [7:0]  ld_byte;
  logic [15:0] ld_half;

  // Store: enable the addressed lanes and replicate data across the word
  always_comb begin
    st_fmt_c = '0;
    case (st_op[1:0])
      2'b00: begin
        st_fmt_c.byteenable = 4'b0001 << st_off;
        st_fmt_c.writedata  = {4{st_wdata[7:0]}};
      end
      2'b01: begin
        st_fmt_c.byteenable = 4'b0011 << {st_off[1], 1'b0};
        st_fmt_c.writedata  = {2{st_wdata[15:0]}};
      end
      default: begin
        st_fmt_c.byteenable = 4'b1111;
        st_fmt_c.writedata  = st_wdata;
      end
    endcase
  end

  // Load: select the addressed lane, then extend to a full word
  always_comb begin
    ld_byte = ld_rdata[7:0];
    case (ld_off)
      2'd1:    ld_byte = ld_rdata[15:8];
      2'd2:    ld_byte = ld_rdata[23:16];
      2'd3:    ld_byte = ld_rdata[31:24];
      default: ld_byte = ld_rdata[7:0];
    endcase
    ld_half = ld_off[1] ? ld_rdata[31:16] : ld_rdata[15:0];
    case (ld_op)
      F3_LB:   ld_data_c = {{24{ld_byte[7]}}, ld_byte};
      F3_LH:   ld_data_c = {{16{ld_half[15]}}, ld_half};
      F3_LBU:  ld_data_c = {24'h0, ld_byte};
      F3_LHU:  ld_data_c = {16'h0, ld_half};
      default: ld_data_c = ld_rdata;
    endcase
  end

endmodule

// File: rtl/lsu.sv
// Load/store unit: issues EX-stage loads/stores on the data bus, stalls the
// pipeline while the bus is busy and registers the formatted load result.
// Optional build macro LSU_MISALIGN_TRAP_EN: misaligned accesses raise
// lsu_ld_misalign/lsu_st_misalign instead of going to the bus.
module lsu
  import core_pkg::*;
(
  input  logic            clk,
  input  logic            rst_b,
  input  logic            ex_mem_read,
  input  logic            ex_mem_write,
  input  logic [2:0]      ex_mem_opcode,
  input  logic [XLEN-1:0] ex_addr,
  input  logic [XLEN-1:0] ex_wdata,
  input  logic            lsu_flush,
  lsu_if.master           dbus,
  output logic            lsu_stall_req,
  output logic [XLEN-1:0] mem_rdata,
  output logic            lsu_ld_misalign,
  output logic            lsu_st_misalign
);

  lsu_state_t      state_q, state_d;
  logic [2:0]      ld_op_q;
  logic [1:0]      ld_off_q;
  logic            mis_c;
  logic            rd_c;
  logic            wr_c;
  logic            load_en_c;
  st_fmt_t         st_fmt_c;
  logic [XLEN-1:0] ld_data_c;

`ifdef LSU_MISALIGN_TRAP_EN
  assign mis_c = is_misaligned(ex_mem_opcode, ex_addr[1:0]);
`else
  assign mis_c = 1'b0;
`endif

  // Lane formatting for the outgoing store and the returning load
  lsu_align u_align (
    .st_op     (ex_mem_opcode),
    .st_off    (ex_addr[1:0]),
    .st_wdata  (ex_wdata),
    .st_fmt_c  (st_fmt_c),
    .ld_op     (ld_op_q),
    .ld_off    (ld_off_q),
    .ld_rdata  (dbus.dbus_readdata),
    .ld_data_c (ld_data_c)
  );

  assign dbus.dbus_read       = rd_c;
  assign dbus.dbus_write      = wr_c;
  assign dbus.dbus_address    = {ex_addr[XLEN-1:2], 2'b00};
  assign dbus.dbus_byteenable = st_fmt_c.byteenable;
  assign dbus.dbus_writedata  = st_fmt_c.writedata;

  // Next state, bus command, stall and misalign flags
  always_comb begin
    state_d         = state_q;
    rd_c            = 1'b0;
    wr_c            = 1'b0;
    lsu_stall_req   = 1'b0;
    load_en_c       = 1'b0;
    lsu_ld_misalign = 1'b0;
    lsu_st_misalign = 1'b0;
    case (state_q)
      LSU_IDLE: begin
        lsu_ld_misalign = ex_mem_read  & mis_c & ~lsu_flush;
        lsu_st_misalign = ex_mem_write & mis_c & ~lsu_flush;
        rd_c = ex_mem_read  & ~lsu_flush & ~mis_c;
        wr_c = ex_mem_write & ~lsu_flush & ~mis_c;
        if (rd_c || wr_c) begin
          if (dbus.dbus_waitrequest) begin
            lsu_stall_req = 1'b1;
          end else if (rd_c) begin
            lsu_stall_req = 1'b1;
            state_d       = LSU_RD_WAIT;
          end
        end
      end
      LSU_RD_WAIT: begin
        lsu_stall_req = 1'b1;
        if (dbus.dbus_readdatavalid) begin
          lsu_stall_req = 1'b0;
          load_en_c     = ~lsu_flush;
          state_d       = LSU_IDLE;
        end else if (lsu_flush) begin
          state_d = LSU_DRAIN;
        end
      end
      LSU_DRAIN: begin
        lsu_stall_req = ex_mem_read | ex_mem_write;
        if (dbus.dbus_readdatavalid) state_d = LSU_IDLE;
      end
      default: state_d = LSU_IDLE;
    endcase
    // Outputs are quiet while reset is held, even though they are combinational
    if (!rst_b) begin
      rd_c            = 1'b0;
      wr_c            = 1'b0;
      lsu_stall_req   = 1'b0;
      lsu_ld_misalign = 1'b0;
      lsu_st_misalign = 1'b0;
    end
  end

  // State, captured load format and load result registers
  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      state_q   <= LSU_IDLE;
      ld_op_q   <= '0;
      ld_off_q  <= '0;
      mem_rdata <= '0;
    end else begin
      state_q <= state_d;
      if (rd_c) begin
        ld_op_q  <= ex_mem_opcode;
        ld_off_q <= ex_addr[1:0];
      end
      if (load_en_c) mem_rdata <= ld_data_c;
    end
  end

endmodule

// File: doc/lsu.md
LSU -- requirements
Module: lsu

Interface
REQ-001 SHALL have ports: clk  input  1  core clock, all state on rising edge.
REQ-002 SHALL have ports: rst_b  input  1  reset, asynchronous, active-low.
REQ-003 SHALL have ports: ex_mem_read / ex_mem_write  input  1  EX-stage load / store valid.
REQ-004 SHALL have ports: ex_mem_opcode  input  3  RISC-V funct3 (LB, LH, LW, LBU, LHU, SB, SH, SW).
REQ-005 SHALL have ports: ex_addr, ex_wdata  input  32  effective address, store data.
REQ-006 SHALL have ports: lsu_flush  input  1  EX flush (trap_take).
REQ-007 SHALL have ports: dbus_read, dbus_write  output  1; dbus_address  output  32; dbus_byteenable  output  4; dbus_writedata  output  32.
REQ-008 SHALL have ports: dbus_waitrequest, dbus_readdatavalid  input  1; dbus_readdata  input  32.
REQ-009 SHALL have ports: lsu_stall_req  output  1  stall request to hazard unit; mem_rdata  output  32  formatted load result, registered.
REQ-010 SHALL have ports: lsu_ld_misalign, lsu_st_misalign  output  1  address-misaligned flags (see Configuration).

Function
REQ-011 SHALL implement FSM states IDLE, RD_WAIT, DRAIN.
REQ-012 IDLE: SHALL drive dbus_read/dbus_write combinationally from ex_mem_read/ex_mem_write, unless lsu_flush or the access is flagged misaligned.
REQ-013 SHALL hold the command and address stable while dbus_waitrequest=1, and SHALL assert lsu_stall_req for those cycles.
REQ-014 Store accepted (waitrequest=0): SHALL complete in the same cycle with no stall; state stays IDLE.
REQ-015 Read accepted: SHALL assert lsu_stall_req that cycle and move to RD_WAIT.
REQ-016 RD_WAIT: SHALL drive no bus command and hold lsu_stall_req=1 until dbus_readdatavalid=1.
REQ-017 On readdatavalid in RD_WAIT: SHALL register the formatted data into mem_rdata, deassert lsu_stall_req that cycle, and return to IDLE.
REQ-018 Best-case load: exactly 1 stall cycle; mem_rdata is valid in the cycle the load occupies MEM.
REQ-019 lsu_flush in RD_WAIT without readdatavalid: SHALL go to DRAIN.
REQ-020 DRAIN: SHALL discard the response (mem_rdata unchanged), issue no command, assert lsu_stall_req only if ex_mem_read|ex_mem_write, and return to IDLE on readdatavalid.
REQ-021 lsu_flush coincident with readdatavalid in RD_WAIT: SHALL discard the data and go to IDLE.
REQ-022 Byteenable: SB 4'b0001<<addr[1:0]; SH 4'b0011<<{addr[1],0}; SW 4'b1111.
REQ-023 Writedata: byte replicated x4 for SB, half replicated x2 for SH.
REQ-024 dbus_address SHALL be {ex_addr[31:2],2'b00}.
REQ-025 Load extract: lane select by addr[1:0]. LB/LH sign-extend; LBU/LHU zero-extend; LW passes through.
REQ-026 The load offset and opcode SHALL be registered at issue, so formatting does not depend on EX inputs in RD_WAIT.
REQ-027 Misaligned means halfword with addr[0]=1, or word with addr[1:0]!=0.

Reset
REQ-028 While rst_b=0: state IDLE; mem_rdata 0; lsu_stall_req, dbus_read, dbus_write, and misalign flags 0.
REQ-029 Reset mid-RD_WAIT: SHALL abandon the transaction without waiting for a response.

Configuration
REQ-030 Macro LSU_MISALIGN_TRAP_EN, when defined: SHALL suppress bus commands for misaligned accesses and assert lsu_ld_misalign/lsu_st_misalign combinationally, with no stall.
REQ-031 Without the macro: SHALL tie the flags to 0 and issue the access with the low address bits ignored, per REQ-022..025 lane rules.

Structure
REQ-032 The FSM state enum and the LSU funct3 encodings SHALL live in core_pkg.
REQ-033 Store byteenable/data and load extract/extend SHALL live in a combinational sub-module lsu_align.

Verification
REQ-034 LW addr 0x100, waitrequest 0, readdatavalid next cycle with 0xDEADBEEF -> stall 1 cycle, mem_rdata 0xDEADBEEF.
REQ-035 LB addr 0x103 with readdata 0x80000000 -> byteenable 4'b1000, mem_rdata 0xFFFFFF80; LBU -> 0x00000080.
REQ-036 SH addr 0x202 data 0x1234 with waitrequest 1 for 3 cycles -> lsu_stall_req 3 cycles, command stable, byteenable 4'b1100, writedata 0x12341234.
REQ-037 LW issued, lsu_flush next cycle, readdatavalid 2 cycles later -> DRAIN, mem_rdata unchanged, no second command until return.
REQ-038 LW addr 0x101 with macro -> dbus_read 0, lsu_ld_misalign 1; without macro -> read at 0x100, flag 0.
REQ-039 rst_b low during RD_WAIT -> all outputs 0, state IDLE immediately.
